// File: rtl/pc_fetch_if.sv
// Bundle of the fetch unit's branch-unit, instruction-memory and decode
// signals. The master side is the fetch unit; the slave side is everything
// around it (branch unit, imem, decode).
//
// Handshakes (valid/ready):
//   - imem: imem_req stays high for the whole wait. imem_valid qualifies
//     imem_rdata and is only accepted while a request is outstanding.
//   - decode: instr_valid stays high, with instr held stable, until the
//     first cycle that instr_ready is also high.
//   - execute: pc_update qualifies nextAddr and halt for one cycle, and is
//     only taken while an instruction is executing.
interface pc_fetch_if;
  logic [31:0] nextAddr;
  logic        pc_update;
  logic        halt;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        instr_ready;
  logic [31:0] nextPC;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  fault;
  logic [31:0] retired;

  modport master (
    input  nextAddr, pc_update, halt, imem_rdata, imem_valid, instr_ready,
    output nextPC, pc, imem_req, imem_addr, instr, instr_valid, halted,
           fault, retired
  );

  modport slave (
    output nextAddr, pc_update, halt, imem_rdata, imem_valid, instr_ready,
    input  nextPC, pc, imem_req, imem_addr, instr, instr_valid, halted,
           fault, retired
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// One instruction in flight at a time: fetch, present to decode, wait for
// execute to resolve it, then fetch the next one. All outputs come from
// registers; nextPC is decoded from the pc register only.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_INC       = 4,
  parameter int          IMEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  pc_fetch_if.master        bus,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [1:0]  FAULT_NONE    = 2'b00;
  localparam logic [1:0]  FAULT_ALIGN   = 2'b01;
  localparam logic [1:0]  FAULT_TIMEOUT = 2'b10;
  localparam logic [31:0] INC           = 32'(PC_INC);
  localparam logic [15:0] TMO_LAST      = 16'(IMEM_TIMEOUT - 1);

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        instr_valid_q;
  logic        imem_req_q;
  logic        halted_q;
  logic [1:0]  fault_q;
  logic [31:0] retired_q;
  logic [15:0] tmo_cnt_q;

  logic [31:0] retired_d;
  logic        misaligned;

  // Saturating retire count and target alignment check, from registers and
  // the execute-stage inputs; only consumed on a pc_update in S_EXEC.
  assign retired_d  = (retired_q == 32'hFFFF_FFFF) ? retired_q : retired_q + 32'd1;
  assign misaligned = (PC_INC == 4) && (bus.nextAddr[1:0] != 2'b00);

  // Main sequencer: state plus every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= FAULT_NONE;
      retired_q     <= 32'd0;
      tmo_cnt_q     <= 16'd0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
          tmo_cnt_q  <= 16'd0;
        end
        S_FETCH: begin
          // A response in the last allowed cycle still counts as on time.
          if (bus.imem_valid) begin
            instr_q       <= bus.imem_rdata;
            tmo_cnt_q     <= 16'd0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_ISSUE;
          end else if (tmo_cnt_q == TMO_LAST) begin
            fault_q    <= FAULT_TIMEOUT;
            imem_req_q <= 1'b0;
            halted_q   <= 1'b1;
            state_q    <= S_HALT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        S_ISSUE: begin
          if (bus.instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (bus.pc_update) begin
            retired_q <= retired_d;
            pc_q      <= bus.nextAddr;
            // Misalignment outranks halt so the fault is never lost.
            if (misaligned) begin
              fault_q  <= FAULT_ALIGN;
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else if (bus.halt) begin
              halted_q <= 1'b1;
              state_q  <= S_HALT;
            end else begin
              imem_req_q <= 1'b1;
              tmo_cnt_q  <= 16'd0;
              state_q    <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state_q <= S_RESET;
        end
      endcase
    end
  end

  assign bus.nextPC      = pc_q + INC;
  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.retired     = retired_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit. Drivers push the expected fetch
// addresses / nextPC values and instruction words into queues; a monitor
// pops and compares whenever a new imem request or instruction appears.
module tb_pc_fetch_unit;

  logic       clk;
  logic       rst;
  logic [2:0] state_o;

  pc_fetch_if bus ();

  pc_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .PC_INC       (4),
    .IMEM_TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_npc_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  initial begin : monitor
    logic prev_req;
    logic prev_iv;
    prev_req = 1'b0;
    prev_iv  = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1 && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          check("unexpected imem_req", bus.imem_addr, 32'hFFFF_FFFF);
        end else begin
          check("imem_addr", bus.imem_addr, exp_addr_q.pop_front());
          check("nextPC", bus.nextPC, exp_npc_q.pop_front());
        end
      end
      if (bus.instr_valid === 1'b1 && !prev_iv) begin
        if (exp_instr_q.size() == 0) check("unexpected instr_valid", bus.instr, 32'hFFFF_FFFF);
        else check("instr", bus.instr, exp_instr_q.pop_front());
      end
      prev_req = (bus.imem_req === 1'b1);
      prev_iv  = (bus.instr_valid === 1'b1);
    end
  end

  // driver tasks
  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] npc);
    exp_addr_q.push_back(addr);
    exp_npc_q.push_back(npc);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.imem_valid  = 1'b0;
    bus.instr_ready = 1'b0;
    bus.pc_update   = 1'b0;
    bus.halt        = 1'b0;
    step();
    check("rst pc", bus.pc, 32'h0);
    check("rst instr", bus.instr, 32'h0);
    check("rst imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst halted", {31'd0, bus.halted}, 32'd0);
    check("rst fault", {30'd0, bus.fault}, 32'd0);
    check("rst retired", bus.retired, 32'd0);
    check("rst state", {29'd0, state_o}, 32'd0);
    repeat (n - 1) step();
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int i;
    for (i = 0; i < 50; i++) begin
      if (bus.imem_req === 1'b1) break;
      step();
    end
    if (i == 50) check("wait imem_req timeout", 32'd0, 32'd1);
  endtask

  task automatic serve(input logic [31:0] data);
    exp_instr_q.push_back(data);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
  endtask

  task automatic accept();
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
  endtask

  task automatic update(input logic [31:0] addr, input logic h);
    bus.pc_update = 1'b1;
    bus.nextAddr  = addr;
    bus.halt      = h;
    step();
    bus.pc_update = 1'b0;
    bus.halt      = 1'b0;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1;
    bus.nextAddr    = 32'h0;
    bus.pc_update   = 1'b0;
    bus.halt        = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.imem_valid  = 1'b0;
    bus.instr_ready = 1'b0;

    // sequential run then branch redirect
    do_reset(2);
    expect_fetch(32'h0, 32'h4);
    wait_req(); serve(32'h1111_0000); accept();
    expect_fetch(32'h4, 32'h8);
    update(32'h4, 1'b0);
    wait_req(); serve(32'h1111_0004); accept();
    expect_fetch(32'h8, 32'hC);
    update(32'h8, 1'b0);
    wait_req(); serve(32'h1111_0008); accept();
    check("exec pc", bus.pc, 32'h8);
    check("exec nextPC", bus.nextPC, 32'hC);
    expect_fetch(32'h40, 32'h44);
    update(32'h40, 1'b0);
    check("retired after 3", bus.retired, 32'd3);

    // decode backpressure
    wait_req(); serve(32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) begin
      check("bp instr_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("bp instr", bus.instr, 32'hDEAD_BEEF);
      check("bp imem_req", {31'd0, bus.imem_req}, 32'd0);
      step();
    end
    accept();
    check("bp accepted", {31'd0, bus.instr_valid}, 32'd0);

    // misaligned target
    expect_fetch(32'h44, 32'h48);
    update(32'h44, 1'b0);
    wait_req(); serve(32'h2222_0044); accept();
    update(32'h42, 1'b1);
    check("mis pc", bus.pc, 32'h42);
    check("mis fault", {30'd0, bus.fault}, 32'd1);
    check("mis halted", {31'd0, bus.halted}, 32'd1);
    check("mis retired", bus.retired, 32'd5);
    update(32'h100, 1'b0);
    step(); step();
    check("halt pc hold", bus.pc, 32'h42);
    check("halt req low", {31'd0, bus.imem_req}, 32'd0);
    check("halt retired hold", bus.retired, 32'd5);

    // aligned halt
    do_reset(2);
    expect_fetch(32'h0, 32'h4);
    wait_req(); serve(32'h3333_0000); accept();
    update(32'h10, 1'b1);
    check("halt halted", {31'd0, bus.halted}, 32'd1);
    check("halt fault", {30'd0, bus.fault}, 32'd0);
    check("halt retired", bus.retired, 32'd1);
    check("halt pc", bus.pc, 32'h10);

    // fetch timeout: no response at all
    do_reset(2);
    expect_fetch(32'h0, 32'h4);
    wait_req();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.imem_req !== 1'b1) break;
      n++;
      step();
    end
    check("tmo req cycles", n, 32'd4);
    check("tmo halted", {31'd0, bus.halted}, 32'd1);
    check("tmo fault", {30'd0, bus.fault}, 32'd2);

    // response in the last allowed cycle
    do_reset(2);
    expect_fetch(32'h0, 32'h4);
    wait_req();
    repeat (3) step();
    serve(32'h4444_0000);
    check("late ok instr_valid", {31'd0, bus.instr_valid}, 32'd1);
    check("late ok fault", {30'd0, bus.fault}, 32'd0);
    check("late ok halted", {31'd0, bus.halted}, 32'd0);

    // reset mid-fetch with a stale response afterwards
    do_reset(1);
    expect_fetch(32'h0, 32'h4);
    wait_req(); serve(32'h5555_0000); accept();
    expect_fetch(32'h20, 32'h24);
    update(32'h20, 1'b0);
    wait_req();
    step();
    expect_fetch(32'h0, 32'h4);
    do_reset(1);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hBAAD_F00D;
    step();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    check("rmf pc", bus.pc, 32'h0);
    check("rmf retired", bus.retired, 32'd0);
    check("rmf imem_req", {31'd0, bus.imem_req}, 32'd1);
    check("rmf instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    serve(32'h600D_0000);
    step();

    check("addr queue empty", exp_addr_q.size(), 32'd0);
    check("instr queue empty", exp_instr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
